vga_timing_gen_param: RTL and testbench
=======================================

Name: vga_timing_gen_param

Overview:
Parametrised VGA/SVGA raster timing generator with a registered colour output stage. It replaces the fixed 640x480 controller. All front porch, sync, back porch and active widths, sync polarities, colour width and pixel-request lead are set by parameters. It adds a run enable, exact (non-off-by-one) line/frame totals, request-address outputs and line/frame-start strobes. It sits between the frame-buffer/paint logic (host side) and the ADV-style video DAC pins.

Parameters:
COLOR_W, 10, bits per colour channel
CNT_W, 11, width of the H/V counters and coordinate outputs
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACT, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of oVGA_H_SYNC (0 = active-low)
VS_POL, 0, asserted level of oVGA_V_SYNC
REQ_LEAD, 2, clocks between oRequest and required iRed/iGreen/iBlue validity; legal range 1..H_SYNC+H_BP

Ports:
iCLK  in  1  pixel clock
iRST_N  in  1  asynchronous active-low reset
iEN  in  1  run enable; 0 holds generator idle at origin
iRed  in  COLOR_W  host red for requested pixel
iGreen  in  COLOR_W  host green
iBlue  in  COLOR_W  host blue
oRequest  out  1  pixel data request
oReq_X  out  CNT_W  active column being requested
oReq_Y  out  CNT_W  active row being requested
oVGA_R  out  COLOR_W  red to DAC; 0 outside active
oVGA_G  out  COLOR_W  green to DAC
oVGA_B  out  COLOR_W  blue to DAC
oVGA_H_SYNC  out  1  horizontal sync, polarity HS_POL
oVGA_V_SYNC  out  1  vertical sync, polarity VS_POL
oVGA_BLANK  out  1  1 during active video, 0 when blanked
oVGA_SYNC  out  1  constant 0
oVGA_CLOCK  out  1  iCLK passed through
oX  out  CNT_W  active column currently on RGB outputs
oY  out  CNT_W  active row currently on RGB outputs
oLine_Start  out  1  one-clock strobe at start of each line
oFrame_Start  out  1  one-clock strobe at start of each frame

Behaviour:
- Derived constants: H_TOT = H_SYNC+H_BP+H_ACT+H_FP; V_TOT = V_SYNC+V_BP+V_ACT+V_FP; H_START = H_SYNC+H_BP; V_START = V_SYNC+V_BP. Line order is sync, back porch, active, front porch.
- Counters: H_Cont runs 0..H_TOT-1 and wraps to 0. V_Cont advances only on the H wrap, runs 0..V_TOT-1 and wraps to 0. Line period is exactly H_TOT clocks; frame period is exactly H_TOT*V_TOT clocks.
- Active region: H_START <= H_Cont < H_START+H_ACT and V_START <= V_Cont < V_START+V_ACT.
- All outputs except oVGA_SYNC and oVGA_CLOCK are registered. Each one reflects the counter state of the previous clock, so outputs lag the counters by exactly 1 clock.
- oVGA_H_SYNC equals HS_POL while H_Cont < H_SYNC, else ~HS_POL.
- oVGA_V_SYNC equals VS_POL while V_Cont < V_SYNC, else ~VS_POL. It changes only in the same clock as the H wrap.
- oVGA_BLANK=1 iff active. oVGA_R/G/B capture iRed/iGreen/iBlue when active, else 0.
- oX/oY = H_Cont-H_START and V_Cont-V_START when active, else 0.
- oRequest is high for exactly H_ACT consecutive clocks on each active line. It is visible in the clock where H_Cont = H_START+x-REQ_LEAD, with oReq_X = x and oReq_Y = active row.
- The host must hold data for pixel x valid at the edge where H_Cont = H_START+x; that edge captures it into oVGA_R/G/B. oReq_X/oReq_Y read 0 while oRequest=0.
- No requests are issued on blank lines. Requests never wrap across lines.
- oLine_Start pulses in the clock after H_Cont=0. oFrame_Start pulses in the clock after H_Cont=0 && V_Cont=0.
- Reset (async, any time): counters=0; syncs at deasserted level (~HS_POL, ~VS_POL); oVGA_BLANK, RGB, oX, oY, oReq_X, oReq_Y, oRequest, oLine_Start, oFrame_Start all 0.
- First edge after reset release with iEN=1: counters advance from 0. The first outputs show origin state, including oFrame_Start=1.
- iEN=0, sampled at any edge, mid-line or mid-frame: counters forced to 0 at that edge. Outputs go to reset values one clock later. No partial request burst continues.
- iEN returning to 1: identical to reset release, so a full new frame starts with an oFrame_Start pulse.
- Counter overflow is illegal: H_TOT and V_TOT must be <= 2^CNT_W. Behaviour with out-of-range parameters is not specified.

Test Plan:
- Defaults, iEN=1, 2 frames -> hsync low 96 of every 800 clocks; vsync low for 2 lines (1600 clocks); oFrame_Start spacing exactly 420000 clocks; oVGA_BLANK high for 640 clocks per line, 480 lines.
- Defaults, iRed = H_Cont mod 1024 driven live -> oRequest first high at H_Cont=142 with oReq_X=0; oVGA_R shows 144 on the first active output clock; 640 requests per active line.
- Small config (H_ACT=4, H_FP=1, H_SYNC=2, H_BP=2, V_ACT=3, V_FP=1, V_SYNC=1, V_BP=1, REQ_LEAD=1) -> line of 9 clocks, frame of 54 clocks; oX sequence 0,1,2,3 on rows 0..2; RGB 0 elsewhere.
- HS_POL=1, VS_POL=1 -> syncs idle low and pulse high; after reset, syncs read 0.
- iEN dropped at H_Cont=300, V_Cont=100 for 5 clocks -> oRequest/BLANK/RGB 0 within 1 clock; on re-enable, oFrame_Start fires one clock later and the frame restarts at origin.
- iRST_N asserted mid-active-line -> all outputs take reset values immediately (asynchronously); after release, same sequence as a cold start.

Source files
------------

// File: rtl/vga_timing_gen_param.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_param
//
// Parametrised VGA/SVGA raster timing generator with a registered colour
// output stage. Sits between the frame-buffer/paint logic (host side) and
// the ADV-style video DAC pins.
//
// Line order is sync, back porch, active, front porch (same for frames).
// Every DAC-side output is registered from the counter state of the previous
// clock, so those outputs trail the counters by exactly one clock. The
// request outputs run REQ_LEAD clocks ahead of the pixel they name, so the
// host has REQ_LEAD clocks to fetch the colour before it is captured.
//
// Ports:
//   iCLK          pixel clock
//   iRST_N        asynchronous active-low reset
//   iEN           run enable; 0 parks the generator idle at the origin
//   iRed/iGreen/iBlue   host colour for the requested pixel
//   oRequest      pixel data request, oReq_X/oReq_Y name the pixel
//   oVGA_R/G/B    colour to the DAC, 0 outside the active area
//   oVGA_H_SYNC   horizontal sync, asserted level HS_POL
//   oVGA_V_SYNC   vertical sync, asserted level VS_POL
//   oVGA_BLANK    1 during active video
//   oVGA_SYNC     tied 0 (no sync-on-green)
//   oVGA_CLOCK    iCLK passed through to the DAC
//   oX/oY         active coordinate currently shown on oVGA_R/G/B
//   oLine_Start   one-clock strobe at the start of each line
//   oFrame_Start  one-clock strobe at the start of each frame
// ---------------------------------------------------------------------------
module vga_timing_gen_param #(
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 11,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int REQ_LEAD = 2
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEN,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [CNT_W-1:0]   oReq_X,
  output logic [CNT_W-1:0]   oReq_Y,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic [CNT_W-1:0]   oX,
  output logic [CNT_W-1:0]   oY,
  output logic               oLine_Start,
  output logic               oFrame_Start
);

  localparam int H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  // Inclusive bounds so that a total of exactly 2^CNT_W still fits the counter.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_START + H_ACT - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_START + V_ACT - 1);
  localparam logic [CNT_W-1:0] REQ_FIRST  = CNT_W'(H_START - REQ_LEAD);
  localparam logic [CNT_W-1:0] REQ_LAST   = CNT_W'(H_START + H_ACT - REQ_LEAD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  logic [CNT_W-1:0]   hCont, vCont;
  logic [CNT_W-1:0]   hNext, vNext;
  logic               hWrap;
  logic               idle;
  logic               outRun;
  logic               hActive, vActive, active;
  logic               reqHit;

  logic               hsD, vsD, blankD, lineD, frameD;
  logic [COLOR_W-1:0] redD, greenD, blueD;
  logic [CNT_W-1:0]   xD, yD;
  logic               reqD;
  logic [CNT_W-1:0]   reqXD, reqYD;

  assign oVGA_SYNC  = 1'b0;
  assign oVGA_CLOCK = iCLK;

  // Next counter values assuming the generator keeps running. The request
  // path looks at these because a request must be visible in the same clock
  // as the counter value it is tied to, one clock ahead of the DAC outputs.
  always_comb begin
    hWrap = (hCont == H_LAST);
    hNext = hWrap ? '0 : hCont + CNT_ONE;
    vNext = vCont;
    if (hWrap) begin
      vNext = (vCont == V_LAST) ? '0 : vCont + CNT_ONE;
    end
    hActive = (hCont >= H_START_C) && (hCont <= H_ACT_LAST);
    vActive = (vCont >= V_START_C) && (vCont <= V_ACT_LAST);
    active  = hActive && vActive;
    reqHit  = (hNext >= REQ_FIRST) && (hNext <= REQ_LAST) &&
              (vNext >= V_START_C) && (vNext <= V_ACT_LAST);
  end

  // Raster counters. Dropping iEN parks both counters at the origin on the
  // same edge, so re-enabling behaves exactly like leaving reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hCont <= '0;
      vCont <= '0;
    end else if (!iEN) begin
      hCont <= '0;
      vCont <= '0;
    end else begin
      hCont <= hNext;
      vCont <= vNext;
    end
  end

  // idle remembers that the counters were parked by the previous edge. While
  // parked and still disabled the DAC outputs hold reset values; the edge that
  // parks the counters still shows the last running state, which is what
  // gives the one-clock lag on disable.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      idle <= 1'b1;
    end else begin
      idle <= !iEN;
    end
  end

  assign outRun = iEN || !idle;

  // Next values of the DAC-side outputs, decoded from the current counters.
  // Defaults are the reset values used while the generator is idle.
  always_comb begin
    hsD    = ~HS_LVL;
    vsD    = ~VS_LVL;
    blankD = 1'b0;
    lineD  = 1'b0;
    frameD = 1'b0;
    redD   = '0;
    greenD = '0;
    blueD  = '0;
    xD     = '0;
    yD     = '0;
    if (outRun) begin
      hsD    = (hCont < H_SYNC_C) ? HS_LVL : ~HS_LVL;
      vsD    = (vCont < V_SYNC_C) ? VS_LVL : ~VS_LVL;
      blankD = active;
      lineD  = (hCont == '0);
      frameD = (hCont == '0) && (vCont == '0);
      if (active) begin
        redD   = iRed;
        greenD = iGreen;
        blueD  = iBlue;
        xD     = hCont - H_START_C;
        yD     = vCont - V_START_C;
      end
    end
  end

  // Request decode. A disabled edge kills the request immediately so no
  // partial burst survives; the coordinates read 0 whenever no request is up.
  always_comb begin
    reqD  = iEN && reqHit;
    reqXD = '0;
    reqYD = '0;
    if (reqD) begin
      reqXD = hNext - REQ_FIRST;
      reqYD = vNext - V_START_C;
    end
  end

  // DAC-side output registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_H_SYNC  <= ~HS_LVL;
      oVGA_V_SYNC  <= ~VS_LVL;
      oVGA_BLANK   <= 1'b0;
      oLine_Start  <= 1'b0;
      oFrame_Start <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oX           <= '0;
      oY           <= '0;
    end else begin
      oVGA_H_SYNC  <= hsD;
      oVGA_V_SYNC  <= vsD;
      oVGA_BLANK   <= blankD;
      oLine_Start  <= lineD;
      oFrame_Start <= frameD;
      oVGA_R       <= redD;
      oVGA_G       <= greenD;
      oVGA_B       <= blueD;
      oX           <= xD;
      oY           <= yD;
    end
  end

  // Host-side request registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRequest <= 1'b0;
      oReq_X   <= '0;
      oReq_Y   <= '0;
    end else begin
      oRequest <= reqD;
      oReq_X   <= reqXD;
      oReq_Y   <= reqYD;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen_param
//
// Two generator instances share one clock and one set of host inputs:
//   dutA: 9-clock lines, 6-line frames (54 clocks), active-low syncs,
//         REQ_LEAD=1.
//   dutB: 16-clock lines on a 4-bit counter (total equals 2^CNT_W),
//         8-line frames (128 clocks), active-high syncs, REQ_LEAD=3.
// The host drives iRed with the number of edges seen so far, so a pixel
// captured at edge n must show n-1 on oVGA_R; iGreen is its complement and
// iBlue is iRed+1.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen_param;

  // One expected-output record, tied to the edge count after release.
  typedef struct {
    int n;
    bit blank;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
    int x;
    int y;
    int r;
    bit req;
    int rx;
    int ry;
  } vecT;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iEN;
  logic [9:0] iRed, iGreen, iBlue;

  logic        aReq, aHs, aVs, aBlank, aSync, aClk, aLs, aFs;
  logic [10:0] aReqX, aReqY, aX, aY;
  logic [9:0]  aR, aG, aB;

  logic        bReq, bHs, bVs, bBlank, bSync, bClk, bLs, bFs;
  logic [3:0]  bReqX, bReqY, bX, bY;
  logic [9:0]  bR, bG, bB;

  int errors = 0;
  int checks = 0;
  int edgeCnt = 0;

  vecT vecA[$];
  vecT vecB[$];

  always #5 iCLK = ~iCLK;

  vga_timing_gen_param #(
    .COLOR_W(10), .CNT_W(11),
    .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(2),
    .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .REQ_LEAD(1)
  ) dutA (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oRequest(aReq), .oReq_X(aReqX), .oReq_Y(aReqY),
    .oVGA_R(aR), .oVGA_G(aG), .oVGA_B(aB),
    .oVGA_H_SYNC(aHs), .oVGA_V_SYNC(aVs), .oVGA_BLANK(aBlank),
    .oVGA_SYNC(aSync), .oVGA_CLOCK(aClk),
    .oX(aX), .oY(aY), .oLine_Start(aLs), .oFrame_Start(aFs)
  );

  vga_timing_gen_param #(
    .COLOR_W(10), .CNT_W(4),
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .REQ_LEAD(3)
  ) dutB (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oRequest(bReq), .oReq_X(bReqX), .oReq_Y(bReqY),
    .oVGA_R(bR), .oVGA_G(bG), .oVGA_B(bB),
    .oVGA_H_SYNC(bHs), .oVGA_V_SYNC(bVs), .oVGA_BLANK(bBlank),
    .oVGA_SYNC(bSync), .oVGA_CLOCK(bClk),
    .oX(bX), .oY(bY), .oLine_Start(bLs), .oFrame_Start(bFs)
  );

  // Drive the host inputs for the next edge, take that edge, then settle on
  // the falling edge where all sampling happens.
  task automatic applyStimulus(input logic en);
    iEN    = en;
    iRed   = 10'(edgeCnt);
    iGreen = iRed ^ 10'h3FF;
    iBlue  = iRed + 10'd1;
    @(posedge iCLK);
    edgeCnt++;
    @(negedge iCLK);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d",
               name, edgeCnt, actual, expected);
    end
  endtask

  // Compare one instance against a table record.
  task automatic checkVec(input string tag, input vecT e,
                          input logic blank, input logic hs, input logic vs,
                          input logic ls, input logic fs,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input logic [31:0] g,
                          input logic [31:0] b, input logic req,
                          input logic [31:0] rx, input logic [31:0] ry);
    int expG, expB;
    expG = e.blank ? ((e.r ^ 1023) & 1023) : 0;
    expB = e.blank ? ((e.r + 1) & 1023) : 0;
    checkOutput({tag, ".blank"}, 32'(blank), 32'(e.blank));
    checkOutput({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    checkOutput({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    checkOutput({tag, ".lineStart"}, 32'(ls), 32'(e.ls));
    checkOutput({tag, ".frameStart"}, 32'(fs), 32'(e.fs));
    checkOutput({tag, ".x"}, x, e.x);
    checkOutput({tag, ".y"}, y, e.y);
    checkOutput({tag, ".red"}, r, e.r);
    checkOutput({tag, ".green"}, g, expG);
    checkOutput({tag, ".blue"}, b, expB);
    checkOutput({tag, ".request"}, 32'(req), 32'(e.req));
    checkOutput({tag, ".reqX"}, rx, e.rx);
    checkOutput({tag, ".reqY"}, ry, e.ry);
  endtask

  // Reset values of both instances; syncs sit at their deasserted levels.
  task automatic checkResetState(input string tag);
    checkOutput({tag, ".A.blank"}, 32'(aBlank), 0);
    checkOutput({tag, ".A.hsync"}, 32'(aHs), 1);
    checkOutput({tag, ".A.vsync"}, 32'(aVs), 1);
    checkOutput({tag, ".A.red"}, 32'(aR), 0);
    checkOutput({tag, ".A.x"}, 32'(aX), 0);
    checkOutput({tag, ".A.request"}, 32'(aReq), 0);
    checkOutput({tag, ".A.reqX"}, 32'(aReqX), 0);
    checkOutput({tag, ".A.frameStart"}, 32'(aFs), 0);
    checkOutput({tag, ".A.lineStart"}, 32'(aLs), 0);
    checkOutput({tag, ".B.hsync"}, 32'(bHs), 0);
    checkOutput({tag, ".B.vsync"}, 32'(bVs), 0);
    checkOutput({tag, ".B.blank"}, 32'(bBlank), 0);
    checkOutput({tag, ".B.request"}, 32'(bReq), 0);
  endtask

  // Watchdog so a broken design can never stall the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Expected outputs after edge n. Outputs show counter state n-1,
    // requests show counter state n.
    //            n  blk hs vs ls fs  x  y   r  req rx ry
    vecA.push_back(vecT'{ 1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{ 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{ 3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{ 9, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{10, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{21, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0});
    vecA.push_back(vecT'{22, 0, 1, 1, 0, 0, 0, 0,  0, 1, 1, 0});
    vecA.push_back(vecT'{23, 1, 1, 1, 0, 0, 0, 0, 22, 1, 2, 0});
    vecA.push_back(vecT'{24, 1, 1, 1, 0, 0, 1, 0, 23, 1, 3, 0});
    vecA.push_back(vecT'{25, 1, 1, 1, 0, 0, 2, 0, 24, 0, 0, 0});
    vecA.push_back(vecT'{26, 1, 1, 1, 0, 0, 3, 0, 25, 0, 0, 0});
    vecA.push_back(vecT'{27, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{28, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{42, 1, 1, 1, 0, 0, 1, 2, 41, 1, 3, 2});
    vecA.push_back(vecT'{44, 1, 1, 1, 0, 0, 3, 2, 43, 0, 0, 0});
    vecA.push_back(vecT'{51, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{54, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{55, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0});
    vecA.push_back(vecT'{77, 1, 1, 1, 0, 0, 0, 0, 76, 1, 2, 0});

    vecB.push_back(vecT'{  1, 0, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{  4, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{ 17, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{ 33, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{ 51, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0});
    vecB.push_back(vecT'{ 55, 1, 0, 0, 0, 0, 0, 0,  54, 1, 4, 0});
    vecB.push_back(vecT'{ 58, 1, 0, 0, 0, 0, 3, 0,  57, 1, 7, 0});
    vecB.push_back(vecT'{ 59, 1, 0, 0, 0, 0, 4, 0,  58, 0, 0, 0});
    vecB.push_back(vecT'{ 62, 1, 0, 0, 0, 0, 7, 0,  61, 0, 0, 0});
    vecB.push_back(vecT'{ 63, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{106, 1, 0, 0, 0, 0, 3, 3, 105, 1, 7, 3});
    vecB.push_back(vecT'{110, 1, 0, 0, 0, 0, 7, 3, 109, 0, 0, 0});
    vecB.push_back(vecT'{112, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{128, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0});
    vecB.push_back(vecT'{129, 0, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0});

    iRST_N = 1'b0;
    iEN    = 1'b1;
    iRed   = '0;
    iGreen = '0;
    iBlue  = '0;
    repeat (3) @(negedge iCLK);
    checkResetState("reset");
    checkOutput("A.vgaSync", 32'(aSync), 0);
    checkOutput("A.vgaClock", 32'(aClk), 32'(iCLK));
    iRST_N = 1'b1;

    // Table-driven run over one full frame of dutB and two of dutA's.
    for (int n = 1; n <= 130; n++) begin
      applyStimulus(1'b1);
      foreach (vecA[i]) begin
        if (vecA[i].n == n)
          checkVec("A", vecA[i], aBlank, aHs, aVs, aLs, aFs, 32'(aX), 32'(aY),
                   32'(aR), 32'(aG), 32'(aB), aReq, 32'(aReqX), 32'(aReqY));
      end
      foreach (vecB[i]) begin
        if (vecB[i].n == n)
          checkVec("B", vecB[i], bBlank, bHs, bVs, bLs, bFs, 32'(bX), 32'(bY),
                   32'(bR), 32'(bG), 32'(bB), bReq, 32'(bReqX), 32'(bReqY));
      end
    end

    // Async reset in the middle of an active line of dutA (state 131 mod 54
    // = 23, column 1 of row 0).
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("midLine.A.blank", 32'(aBlank), 1);
    checkOutput("midLine.A.x", 32'(aX), 1);
    #2 iRST_N = 1'b0;
    #1 checkResetState("asyncReset");
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Cold start again: the first edge shows the origin.
    applyStimulus(1'b1);
    checkOutput("restart.A.frameStart", 32'(aFs), 1);
    checkOutput("restart.A.lineStart", 32'(aLs), 1);
    checkOutput("restart.A.hsync", 32'(aHs), 0);
    checkOutput("restart.B.frameStart", 32'(bFs), 1);
    checkOutput("restart.B.hsync", 32'(bHs), 1);
    applyStimulus(1'b1);
    checkOutput("restart.A.frameStart2", 32'(aFs), 0);
    repeat (21) applyStimulus(1'b1);
    checkOutput("restart.A.blank", 32'(aBlank), 1);
    checkOutput("restart.A.x", 32'(aX), 0);
    checkOutput("restart.A.red", 32'(aR), 32'(edgeCnt - 1));
    applyStimulus(1'b1);
    checkOutput("restart.A.x1", 32'(aX), 1);

    // Drop iEN for five edges mid-line. The first disabled edge still shows
    // the last running pixel but already kills the request.
    applyStimulus(1'b0);
    checkOutput("disable.A.request", 32'(aReq), 0);
    checkOutput("disable.A.x", 32'(aX), 2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0);
      checkOutput("disabled.A.blank", 32'(aBlank), 0);
      checkOutput("disabled.A.red", 32'(aR), 0);
      checkOutput("disabled.A.request", 32'(aReq), 0);
      checkOutput("disabled.A.frameStart", 32'(aFs), 0);
      checkOutput("disabled.A.hsync", 32'(aHs), 1);
      checkOutput("disabled.B.hsync", 32'(bHs), 0);
      checkOutput("disabled.B.frameStart", 32'(bFs), 0);
    end

    // Re-enable: full new frame from the origin.
    applyStimulus(1'b1);
    checkOutput("reenable.A.frameStart", 32'(aFs), 1);
    checkOutput("reenable.A.lineStart", 32'(aLs), 1);
    checkOutput("reenable.A.hsync", 32'(aHs), 0);
    checkOutput("reenable.A.blank", 32'(aBlank), 0);
    checkOutput("reenable.B.frameStart", 32'(bFs), 1);
    repeat (22) applyStimulus(1'b1);
    checkOutput("reenable.A.blank22", 32'(aBlank), 1);
    checkOutput("reenable.A.x22", 32'(aX), 0);
    checkOutput("reenable.A.y22", 32'(aY), 0);
    checkOutput("reenable.A.red22", 32'(aR), 32'(edgeCnt - 1));
    checkOutput("reenable.A.reqX22", 32'(aReqX), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
